// File: rtl/glitch_sequencer.sv
// Edge-counting glitch sequencer: waits for io_target rising edges on sc_io,
// delays clk_delay cycles, then emits one or more glitch pulses separated by gaps.
module glitch_sequencer #(
  parameter logic [15:0] IO_TARGET_RST = 16'd720,
  parameter logic [31:0] DELAY_RST     = 32'd13255,
  parameter logic [15:0] WIDTH_RST     = 16'd4
) (
  input  logic        sc_clk,
  input  logic        sc_reset,
  input  logic        sc_io,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        arm,
  input  logic        abort,
  output logic        glitch_out,
  output logic        trigger,
  output logic        busy,
  output logic        done,
  output logic [15:0] edge_count,
  output logic        led_out,
  output logic        led_out_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_GLITCH,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        s1_d, s2_d, s3_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] edge_count_q, edge_count_d;
  logic        first_q, first_d;
  logic [15:0] io_target_q, io_target_d;
  logic [31:0] clk_delay_q, clk_delay_d;
  logic [15:0] glitch_width_q, glitch_width_d;
  logic [23:0] gap_q, gap_d;
  logic [7:0]  rep_q, rep_d;
  logic        glitch_q, glitch_d;
  logic        trigger_q, trigger_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        edge_det;
  logic [31:0] width_len;
  logic [31:0] gap_len;
  logic [7:0]  rep_len;

  assign edge_det  = s2_q & ~s3_q;
  assign width_len = {16'd0, (glitch_width_q == 16'd0) ? 16'd1 : glitch_width_q};
  assign gap_len   = {8'd0, (gap_q == 24'd0) ? 24'd1 : gap_q};
  assign rep_len   = (rep_q == 8'd0) ? 8'd1 : rep_q;

  // Abort must also refuse a config write offered in the same cycle.
  assign cfg_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && !abort;

  always_comb begin
    s1_d           = sc_io;
    s2_d           = s1_q;
    s3_d           = s2_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    edge_count_d   = edge_count_q;
    first_d        = first_q;
    io_target_d    = io_target_q;
    clk_delay_d    = clk_delay_q;
    glitch_width_d = glitch_width_q;
    gap_d          = gap_q;
    rep_d          = rep_q;

    if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        2'd0:    io_target_d    = cfg_data[15:0];
        2'd1:    clk_delay_d    = cfg_data;
        2'd2:    glitch_width_d = cfg_data[15:0];
        default: begin
          gap_d = cfg_data[31:8];
          rep_d = cfg_data[7:0];
        end
      endcase
    end

    if (abort) begin
      state_d      = S_IDLE;
      cnt_d        = 32'd0;
      rem_d        = 8'd0;
      edge_count_d = 16'd0;
      first_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d      = S_ARMED;
            edge_count_d = 16'd0;
            rem_d        = rep_len;
            first_d      = 1'b1;
            cnt_d        = 32'd0;
          end
        end
        S_ARMED: begin
          if (edge_det && (edge_count_q != 16'hFFFF))
            edge_count_d = edge_count_q + 16'd1;
          // Compare the registered count so exit lands one cycle after the final edge.
          if (edge_count_q == io_target_q) begin
            state_d = (clk_delay_q == 32'd0) ? S_GLITCH : S_DELAY;
            cnt_d   = 32'd1;
          end
        end
        S_DELAY: begin
          if (cnt_q == clk_delay_q) begin
            state_d = S_GLITCH;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_GLITCH: begin
          if (cnt_q == width_len) begin
            rem_d = rem_q - 8'd1;
            if (rem_q > 8'd1) begin
              state_d = S_GAP;
              cnt_d   = 32'd1;
            end else begin
              state_d = S_DONE;
              cnt_d   = 32'd0;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == gap_len) begin
            state_d = S_GLITCH;
            cnt_d   = 32'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered decodes of the next state.
    trigger_d = (state_d == S_GLITCH) && first_q;
    if (state_d == S_GLITCH)
      first_d = 1'b0;
    glitch_d = (state_d == S_GLITCH);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d == S_ARMED) || (state_d == S_DELAY) ||
               (state_d == S_GLITCH) || (state_d == S_GAP);
  end

  always_ff @(posedge sc_clk or posedge sc_reset) begin
    if (sc_reset) begin
      state_q        <= S_IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= 32'd0;
      rem_q          <= 8'd0;
      edge_count_q   <= 16'd0;
      first_q        <= 1'b0;
      io_target_q    <= IO_TARGET_RST;
      clk_delay_q    <= DELAY_RST;
      glitch_width_q <= WIDTH_RST;
      gap_q          <= 24'd1;
      rep_q          <= 8'd1;
      glitch_q       <= 1'b0;
      trigger_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      edge_count_q   <= edge_count_d;
      first_q        <= first_d;
      io_target_q    <= io_target_d;
      clk_delay_q    <= clk_delay_d;
      glitch_width_q <= glitch_width_d;
      gap_q          <= gap_d;
      rep_q          <= rep_d;
      glitch_q       <= glitch_d;
      trigger_q      <= trigger_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign glitch_out = glitch_q;
  assign trigger    = trigger_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_count = edge_count_q;
  assign led_out    = busy_q;
  assign led_out_2  = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: table of sequences with hand-computed
// timing, plus hand-written abort, stall and asynchronous-reset sequences.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        sc_reset;
  logic        sc_io;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        arm;
  logic        abort;
  logic        glitch_out;
  logic        trigger;
  logic        busy;
  logic        done;
  logic [15:0] edge_count;
  logic        led_out;
  logic        led_out_2;

  int checks = 0;
  int errors = 0;

  glitch_sequencer dut (
    .sc_clk     (clk),
    .sc_reset   (sc_reset),
    .sc_io      (sc_io),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .arm        (arm),
    .abort      (abort),
    .glitch_out (glitch_out),
    .trigger    (trigger),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .led_out    (led_out),
    .led_out_2  (led_out_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tgt;
    logic [31:0] dly;
    logic [15:0] wid;
    logic [23:0] gap;
    logic [7:0]  rep;
    int          npulses;
    int          exp_first;
    int          exp_high;
    int          exp_pulses;
    int          exp_done;
    int          exp_edges;
  } vec_t;

  vec_t vecs [6];

  int m_first, m_high, m_pulses, m_trig_cnt, m_trig_idx, m_done, m_flag_bad;
  logic [15:0] m_edges;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    #1;
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_all(input logic [15:0] tgt, input logic [31:0] dly, input logic [15:0] wid,
                         input logic [23:0] gp, input logic [7:0] rep);
    cfg_write(2'd0, {16'd0, tgt});
    cfg_write(2'd1, dly);
    cfg_write(2'd2, {16'd0, wid});
    cfg_write(2'd3, {gp, rep});
  endtask

  // Arms, then samples one cycle per posedge; c=1 is the first cycle after arm.
  task automatic run(input int npulses);
    logic prev;
    m_first = -1; m_high = 0; m_pulses = 0; m_trig_cnt = 0;
    m_trig_idx = -1; m_done = -1; m_flag_bad = 0; m_edges = 16'd0;
    prev = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (glitch_out && m_first < 0) m_first = c;
      if (glitch_out) m_high++;
      if (glitch_out && !prev) m_pulses++;
      prev = glitch_out;
      if (trigger) begin
        m_trig_cnt++;
        m_trig_idx = c;
      end
      if (led_out !== busy || led_out_2 !== done) m_flag_bad++;
      if (done) begin
        m_done  = c;
        m_edges = edge_count;
        break;
      end
      if (!busy) m_flag_bad++;
      sc_io = (npulses > 0) && (((c - 1) / 4) < npulses) && (((c - 1) % 4) < 2);
      tick();
    end
    sc_io = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int acc;

    vecs[0] = '{16'd3, 32'd10, 16'd4, 24'd1, 8'd1, 3,  23, 4, 1, 27, 3};
    vecs[1] = '{16'd0, 32'd0,  16'd2, 24'd5, 8'd3, 0,  2,  6, 3, 18, 0};
    vecs[2] = '{16'd0, 32'd1,  16'd0, 24'd0, 8'd0, 0,  3,  1, 1, 4,  0};
    vecs[3] = '{16'd1, 32'd0,  16'd1, 24'd2, 8'd2, 1,  5,  2, 2, 9,  1};
    vecs[4] = '{16'd2, 32'd3,  16'd3, 24'd0, 8'd2, 2,  12, 6, 2, 19, 2};
    vecs[5] = '{16'd1, 32'd4,  16'd0, 24'd0, 8'd0, 10, 9,  1, 1, 10, 1};

    sc_reset = 1'b1; sc_io = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0;
    cfg_data = 32'd0; arm = 1'b0; abort = 1'b0;
    #3;
    chk("reset_outputs", {26'd0, glitch_out, trigger, busy, done, led_out, led_out_2}, 32'd0);
    chk("reset_edge_count", {16'd0, edge_count}, 32'd0);
    #4;
    sc_reset = 1'b0;
    tick();
    chk("idle_after_reset", {29'd0, busy, done, glitch_out}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      cfg_all(vecs[i].tgt, vecs[i].dly, vecs[i].wid, vecs[i].gap, vecs[i].rep);
      run(vecs[i].npulses);
      chk($sformatf("v%0d_first_glitch", i), m_first, vecs[i].exp_first);
      chk($sformatf("v%0d_trigger_idx", i), m_trig_idx, vecs[i].exp_first);
      chk($sformatf("v%0d_trigger_cnt", i), m_trig_cnt, 1);
      chk($sformatf("v%0d_high_cycles", i), m_high, vecs[i].exp_high);
      chk($sformatf("v%0d_pulses", i), m_pulses, vecs[i].exp_pulses);
      chk($sformatf("v%0d_done_idx", i), m_done, vecs[i].exp_done);
      chk($sformatf("v%0d_edge_count", i), {16'd0, m_edges}, vecs[i].exp_edges);
      chk($sformatf("v%0d_flags", i), m_flag_bad, 0);
      tick();
      tick();
      chk($sformatf("v%0d_done_hold", i), {29'd0, done, busy, led_out_2}, 32'b101);
    end

    // Abort in the second cycle of an 8-wide glitch, together with arm and a write.
    cfg_all(16'd0, 32'd2, 16'd8, 24'd1, 8'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (4) tick();
    chk("abort_pre_glitch", {31'd0, glitch_out}, 32'd1);
    abort = 1'b1; arm = 1'b1; cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 32'd1;
    #1;
    chk("abort_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    tick();
    abort = 1'b0; arm = 1'b0; cfg_valid = 1'b0;
    chk("abort_outputs", {26'd0, glitch_out, trigger, busy, done, led_out, led_out_2}, 32'd0);
    repeat (3) tick();
    chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);
    run(0);
    chk("abort_write_dropped", m_high, 8);
    chk("abort_rerun_first", m_first, 4);

    // Write offered while busy stalls and lands in the first DONE cycle.
    cfg_all(16'd0, 32'd5, 16'd1, 24'd1, 8'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 32'd3;
    bad = 0; acc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        chk("stall_ready_in_done", {31'd0, cfg_ready}, 32'd1);
        chk("stall_done_cycle", c, 8);
        tick();
        cfg_valid = 1'b0;
        acc = 1;
        break;
      end
      if (cfg_ready) bad++;
      tick();
    end
    chk("stall_ready_low_busy", bad, 0);
    chk("stall_accepted", acc, 1);
    run(0);
    chk("stall_new_width", m_high, 3);
    chk("stall_new_done", m_done, 10);

    // Asynchronous reset in the middle of DELAY.
    cfg_all(16'd0, 32'd50, 16'd1, 24'd1, 8'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (4) tick();
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #3;
    sc_reset = 1'b1;
    #1;
    chk("rst_async_outputs", {26'd0, glitch_out, trigger, busy, done, led_out, led_out_2}, 32'd0);
    chk("rst_async_edges", {16'd0, edge_count}, 32'd0);
    #2;
    sc_reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy || done || glitch_out) bad++;
    end
    chk("rst_stays_idle", bad, 0);
    // io_target back at its reset value: one edge counted, still armed.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sc_io = 1'b1;
    tick();
    tick();
    sc_io = 1'b0;
    repeat (7) tick();
    chk("rst_cfg_armed", {30'd0, busy, glitch_out}, 32'b10);
    chk("rst_cfg_edge_count", {16'd0, edge_count}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_from_armed", {15'd0, busy, edge_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
